// File: rtl/combo_lock_pkg.sv
// Shared types and 7-segment glyphs for the combination-lock controller.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package combo_lock_pkg;

    typedef enum logic [1:0] {CLOSED, ARMED, OPEN, DENIED} state_t;

    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_S     = 7'h12;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_T     = 7'h07;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_Y     = 7'h11;
    localparam logic [6:0] SEG_EQ    = 7'h37;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_LD    = 7'h21;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Values above 9 render blank rather than garbage.
    function automatic logic [6:0] digit2seg(input logic [6:0] d);
        case (d)
            7'd0:    return SEG_DIGIT[0];
            7'd1:    return SEG_DIGIT[1];
            7'd2:    return SEG_DIGIT[2];
            7'd3:    return SEG_DIGIT[3];
            7'd4:    return SEG_DIGIT[4];
            7'd5:    return SEG_DIGIT[5];
            7'd6:    return SEG_DIGIT[6];
            7'd7:    return SEG_DIGIT[7];
            7'd8:    return SEG_DIGIT[8];
            7'd9:    return SEG_DIGIT[9];
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [13:0] bin2seg2(input logic [6:0] sec);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = sec / 7'd10;
        ones = sec % 7'd10;
        return {(tens == 7'd0) ? SEG_BLANK : digit2seg(tens), digit2seg(ones)};
    endfunction

endpackage

// File: rtl/combo_lock_ctrl_timer.sv
// Lockout countdown: loads LOCKOUT_SEC on start, decrements sec every
// TICKS_PER_SEC clocks, pulses done on the final wrap.
module lockout_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int LOCKOUT_SEC   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [6:0] sec,
    output logic       done
);
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

    logic [TW-1:0] tick;
    logic          wrap;

    // sec==0 doubles as the idle flag.
    assign wrap = (sec != 7'd0) && (tick == TICK_LAST);
    assign done = wrap && (sec == 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec  <= 7'd0;
            tick <= '0;
        end else if (start) begin
            sec  <= 7'(LOCKOUT_SEC);
            tick <= '0;
        end else if (sec != 7'd0) begin
            if (wrap) begin
                tick <= '0;
                sec  <= sec - 7'd1;
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end
endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock controller: submit-edge detect, lock FSM, tries/code
// registers and a registered six-digit glyph mux.
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int                CODE_W        = 8,
    parameter logic [CODE_W-1:0] DEFAULT_CODE  = 8'h49,
    parameter int                MAX_TRIES     = 3,
    parameter int                TICKS_PER_SEC = 50_000_000,
    parameter int                LOCKOUT_SEC   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              submit,
    input  logic              prog_en,
    input  logic [CODE_W-1:0] code_in,
    output logic [6:0]        led0,
    output logic [6:0]        led1,
    output logic [6:0]        led2,
    output logic [6:0]        led3,
    output logic [6:0]        led4,
    output logic [6:0]        led5,
    output logic              open_o,
    output logic              locked_o
);
    localparam int TRW = $clog2(MAX_TRIES + 1);
    localparam logic [TRW-1:0] TRIES_FULL = TRW'(MAX_TRIES);
    localparam logic [41:0] DISP_CLOSED = {SEG_C, SEG_L, SEG_O, SEG_S, SEG_E, SEG_D};

    state_t            state, nxt_state;
    logic [TRW-1:0]    tries, nxt_tries;
    logic [CODE_W-1:0] code, nxt_code;
    logic              submit_q, sub_p;
    logic              tmr_start, tmr_done;
    logic [6:0]        sec;
    logic [41:0]       disp_q, disp_d;

    assign sub_p = submit & ~submit_q;

    lockout_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .LOCKOUT_SEC  (LOCKOUT_SEC)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(tmr_start),
        .sec  (sec),
        .done (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLOSED;
            tries    <= TRIES_FULL;
            code     <= DEFAULT_CODE;
            submit_q <= 1'b0;
        end else begin
            state    <= nxt_state;
            tries    <= nxt_tries;
            code     <= nxt_code;
            submit_q <= submit;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_tries = tries;
        nxt_code  = code;
        tmr_start = 1'b0;
        case (state)
            CLOSED: if (en) nxt_state = ARMED;
            ARMED: begin
                // Dropping en takes priority over a same-cycle attempt.
                if (!en) begin
                    nxt_state = CLOSED;
                end else if (sub_p) begin
                    if (code_in == code) begin
                        nxt_state = OPEN;
                        nxt_tries = TRIES_FULL;
                    end else if (tries > TRW'(1)) begin
                        nxt_tries = tries - TRW'(1);
                    end else begin
                        nxt_state = DENIED;
                        nxt_tries = '0;
                        tmr_start = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (!en)                   nxt_state = CLOSED;
                else if (sub_p && prog_en) nxt_code  = code_in;
            end
            DENIED: begin
                if (tmr_done) begin
                    nxt_tries = TRIES_FULL;
                    nxt_state = en ? ARMED : CLOSED;
                end
            end
            default: nxt_state = CLOSED;
        endcase
    end

    always_comb begin
        disp_d = DISP_CLOSED;
        case (state)
            CLOSED:  disp_d = DISP_CLOSED;
            ARMED:   disp_d = {SEG_T, SEG_R, SEG_Y, SEG_S, SEG_EQ, digit2seg(7'(tries))};
            OPEN:    disp_d = {SEG_O, SEG_P, SEG_E, SEG_N, SEG_BLANK, SEG_BLANK};
            DENIED:  disp_d = {SEG_LD, SEG_E, SEG_N, SEG_BLANK, bin2seg2(sec)};
            default: disp_d = DISP_CLOSED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q   <= DISP_CLOSED;
            open_o   <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            disp_q   <= disp_d;
            open_o   <= (state == OPEN);
            locked_o <= (state == DENIED);
        end
    end

    assign {led5, led4, led3, led2, led1, led0} = disp_q;
endmodule
